alu_seq: RTL and testbench

//   Registered, parametrised successor to the 16-bit datapath ALU; executes the full

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_mul_seq.sv | 60 ++++++
 rtl/alu_seq.sv | 204 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcode and extended-opcode values,
// PSR bit positions and the control FSM state type.
package alu_pkg;

    // Primary opcodes
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    // Extended opcodes under OP_RTYPE
    localparam logic [3:0] EXT_AND  = 4'b0001;
    localparam logic [3:0] EXT_OR   = 4'b0010;
    localparam logic [3:0] EXT_XOR  = 4'b0011;
    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_SUB  = 4'b1001;
    localparam logic [3:0] EXT_CMP  = 4'b1011;
    localparam logic [3:0] EXT_MOV  = 4'b1101;
    localparam logic [3:0] EXT_MUL  = 4'b1110;

    // Extended opcodes under OP_SHIFT
    localparam logic [3:0] EXT_LSHI = 4'b0000;
    localparam logic [3:0] EXT_RSHI = 4'b0001;
    localparam logic [3:0] EXT_LSH  = 4'b0100;

    // Bit positions inside the 5-bit flag field (PSR[4:0])
    localparam int PSR_C = 4;
    localparam int PSR_L = 3;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_N = 0;

    // Control FSM: IDLE accepts ops, MUL waits for the iterative multiplier
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier returning the low WIDTH bits of a*b.
// Bit 0 of the multiplier is consumed in the start cycle, then one bit per
// cycle; `product` is the combinational next accumulator so that it holds the
// complete result in the cycle `done` is high.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;
    logic             active;
    logic [WIDTH-1:0] acc_next;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign product  = acc_next;
    assign done     = active && (count == LAST);

    // Operand load on start, then one partial product per cycle until the last bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            active <= 1'b0;
        end else if (start) begin
            acc    <= b[0] ? a : '0;
            mcand  <= a << 1;
            mplier <= b >> 1;
            count  <= CW'(1);
            active <= 1'b1;
        end else if (active) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (count == LAST) begin
                active <= 1'b0;
                count  <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU between register read and writeback. Single-cycle ops return
// one cycle after acceptance; MUL runs on the iterative multiplier and returns
// WIDTH cycles after acceptance. Owns the PSR so flags persist across ops.
//
// Handshake: an op transfers on a rising edge where in_valid && in_ready;
// in_ready is high whenever the FSM is IDLE and does not depend on in_valid.
// out_valid is a one-cycle pulse with no backpressure; result and PSR hold
// their values between pulses.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int IMM_W  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opCode,
    input  logic [3:0]       opExt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [7:0]       PSR,
    output alu_state_e       dbg_state
);

    // Shift amount field is signed and one bit wider than log2(WIDTH)
    localparam int SW = $clog2(WIDTH) + 1;

    alu_state_e       state;
    alu_state_e       state_next;
    logic [4:0]       flags;
    logic [4:0]       flags_next;
    logic [WIDTH-1:0] res_next;
    logic             write_res;
    logic             is_mul;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] imm_zext;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             add_ovf;
    logic             sub_ovf;

    // Logical shift: non-negative amount shifts left, negative shifts right;
    // invert swaps the direction. Magnitudes of WIDTH or more clear the value.
    function automatic logic [WIDTH-1:0] shift_op(input logic [WIDTH-1:0] val,
                                                  input logic [SW-1:0]    amt,
                                                  input logic             invert);
        logic [SW-1:0] mag;
        logic          go_left;
        go_left = ~amt[SW-1] ^ invert;
        mag     = amt[SW-1] ? (~amt + SW'(1)) : amt;
        if (mag >= SW'(WIDTH)) begin
            return '0;
        end else if (go_left) begin
            return val << mag;
        end else begin
            return val >> mag;
        end
    endfunction

    assign imm_sext = WIDTH'($signed(b[IMM_W-1:0]));
    assign imm_zext = WIDTH'(b[IMM_W-1:0]);

    // Arithmetic immediates are sign-extended; everything else uses b directly
    assign opnd = (opCode == OP_ADDI || opCode == OP_SUBI || opCode == OP_CMPI) ? imm_sext : b;

    assign sum_ext  = {1'b0, a} + {1'b0, opnd};
    assign diff_ext = {1'b0, a} - {1'b0, opnd};
    assign add_ovf  = (a[WIDTH-1] == opnd[WIDTH-1]) && (sum_ext[WIDTH-1]  != a[WIDTH-1]);
    assign sub_ovf  = (a[WIDTH-1] != opnd[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);

    assign in_ready  = (state == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && is_mul;
    assign PSR       = {3'b000, flags};
    assign dbg_state = state;

    // Decode and single-cycle datapath; unsupported encodings yield 0 with flags held
    always_comb begin
        res_next   = '0;
        flags_next = flags;
        write_res  = 1'b1;
        is_mul     = 1'b0;
        case (opCode)
            OP_RTYPE: begin
                case (opExt)
                    EXT_ADD: begin
                        res_next          = sum_ext[WIDTH-1:0];
                        flags_next[PSR_C] = sum_ext[WIDTH];
                        flags_next[PSR_F] = add_ovf;
                    end
                    EXT_SUB: begin
                        res_next          = diff_ext[WIDTH-1:0];
                        flags_next[PSR_C] = diff_ext[WIDTH];
                        flags_next[PSR_F] = sub_ovf;
                    end
                    EXT_CMP: begin
                        write_res         = 1'b0;
                        flags_next[PSR_L] = diff_ext[WIDTH];
                        flags_next[PSR_Z] = (a == opnd);
                        flags_next[PSR_N] = diff_ext[WIDTH-1] ^ sub_ovf;
                    end
                    EXT_AND: res_next = a & b;
                    EXT_OR:  res_next = a | b;
                    EXT_XOR: res_next = a ^ b;
                    EXT_MOV: res_next = b;
                    EXT_MUL: is_mul   = MUL_EN;
                    default: res_next = '0;
                endcase
            end
            OP_ANDI: res_next = a & imm_zext;
            OP_ORI:  res_next = a | imm_zext;
            OP_XORI: res_next = a ^ imm_zext;
            OP_MOVI: res_next = imm_zext;
            OP_MEM:  res_next = sum_ext[WIDTH-1:0];
            OP_ADDI: begin
                res_next          = sum_ext[WIDTH-1:0];
                flags_next[PSR_C] = sum_ext[WIDTH];
                flags_next[PSR_F] = add_ovf;
            end
            OP_SUBI: begin
                res_next          = diff_ext[WIDTH-1:0];
                flags_next[PSR_C] = diff_ext[WIDTH];
                flags_next[PSR_F] = sub_ovf;
            end
            OP_CMPI: begin
                write_res         = 1'b0;
                flags_next[PSR_L] = diff_ext[WIDTH];
                flags_next[PSR_Z] = (a == opnd);
                flags_next[PSR_N] = diff_ext[WIDTH-1] ^ sub_ovf;
            end
            OP_SHIFT: begin
                case (opExt)
                    EXT_LSH, EXT_LSHI: res_next = shift_op(a, b[SW-1:0], 1'b0);
                    EXT_RSHI:          res_next = shift_op(a, b[SW-1:0], 1'b1);
                    default:           res_next = '0;
                endcase
            end
            OP_LUI:  res_next = imm_zext << (WIDTH - IMM_W);
            default: res_next = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: park in MUL until the multiplier signals its last cycle
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (mul_start) state_next = ST_MUL;
            ST_MUL:  if (mul_done)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output and PSR registers; CMP-type ops leave the result register untouched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            out_valid <= (accept && !is_mul) || mul_done;
            if (accept && !is_mul) begin
                if (write_res) begin
                    result <= res_next;
                end
                flags <= flags_next;
            end else if (mul_done) begin
                result <= mul_product;
            end
        end
    end

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (a),
        .b      (b),
        .done   (mul_done),
        .product(mul_product)
    );

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=16, IMM_W=8: directed vectors, a MUL timing and
// backpressure sequence, reset during MUL, then randomized ops. A reference
// model computes each expected result/PSR with plain integer arithmetic and
// queues it; a monitor pops and compares whenever out_valid is seen.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 16;

    typedef enum {K_ADD, K_SUB, K_CMP, K_AND, K_OR, K_XOR, K_MOV,
                  K_MEM, K_LSH, K_RSH, K_LUI, K_MUL, K_BAD} kind_e;

    // {opCode, opExt} encodings used by the random phase
    localparam logic [7:0] ENC_TAB [20] = '{
        8'h05, 8'h09, 8'h0B, 8'h01, 8'h02, 8'h03, 8'h0D, 8'h0E, 8'h10, 8'h20,
        8'h30, 8'h50, 8'h90, 8'hB0, 8'hD0, 8'h40, 8'h84, 8'h80, 8'h81, 8'hF0
    };

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opCode;
    logic [3:0]       opExt;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             out_valid;
    logic [W-1:0]     result;
    logic [7:0]       PSR;
    alu_state_e       dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [23:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [23:0] mon_e;
    int          mon_c;

    // reference model architectural state
    bit          m_c, m_l, m_f, m_z, m_n;
    logic [15:0] m_result;

    alu_seq #(
        .WIDTH (W),
        .IMM_W (8),
        .MUL_EN(1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opCode   (opCode),
        .opExt    (opExt),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .result   (result),
        .PSR      (PSR),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic kind_e decode(input logic [3:0] op, input logic [3:0] ext);
        case (op)
            4'h0: begin
                case (ext)
                    4'h5: return K_ADD;
                    4'h9: return K_SUB;
                    4'hB: return K_CMP;
                    4'h1: return K_AND;
                    4'h2: return K_OR;
                    4'h3: return K_XOR;
                    4'hD: return K_MOV;
                    4'hE: return K_MUL;
                    default: return K_BAD;
                endcase
            end
            4'h1: return K_AND;
            4'h2: return K_OR;
            4'h3: return K_XOR;
            4'h4: return K_MEM;
            4'h5: return K_ADD;
            4'h8: begin
                case (ext)
                    4'h0, 4'h4: return K_LSH;
                    4'h1:       return K_RSH;
                    default:    return K_BAD;
                endcase
            end
            4'h9: return K_SUB;
            4'hB: return K_CMP;
            4'hD: return K_MOV;
            4'hF: return K_LUI;
            default: return K_BAD;
        endcase
    endfunction

    task automatic model_reset();
        m_c = 0; m_l = 0; m_f = 0; m_z = 0; m_n = 0;
        m_result = '0;
    endtask

    task automatic model_op(input logic [3:0] op, input logic [3:0] ext,
                            input logic [15:0] av, input logic [15:0] bv, output int lat);
        kind_e  k;
        longint ua, ub, sa, sb, r;
        int     sh;
        bit     keep;
        k    = decode(op, ext);
        lat  = 1;
        keep = 0;
        r    = 0;
        ua   = longint'(av);
        ub   = longint'(bv);
        if (op inside {4'h5, 4'h9, 4'hB})
            ub = longint'(bv[7:0]) + (bv[7] ? 64'hFF00 : 64'h0);
        else if (op inside {4'h1, 4'h2, 4'h3, 4'hD})
            ub = longint'(bv[7:0]);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        case (k)
            K_ADD: begin
                r   = ua + ub;
                m_c = (r > 65535);
                m_f = ((sa + sb) > 32767) || ((sa + sb) < -32768);
            end
            K_SUB: begin
                r   = ua - ub;
                m_c = (ua < ub);
                m_f = ((sa - sb) > 32767) || ((sa - sb) < -32768);
            end
            K_CMP: begin
                keep = 1;
                m_l  = (ua < ub);
                m_z  = (ua == ub);
                m_n  = (sa < sb);
            end
            K_AND: r = ua & ub;
            K_OR:  r = ua | ub;
            K_XOR: r = ua ^ ub;
            K_MOV: r = ub;
            K_MEM: r = ua + ub;
            K_LSH, K_RSH: begin
                sh = int'(bv[4:0]);
                if (sh >= 16) sh = sh - 32;
                if (k == K_RSH) sh = -sh;
                if (sh >= 16 || sh <= -16) r = 0;
                else if (sh >= 0)          r = ua << sh;
                else                       r = ua >> (-sh);
            end
            K_LUI: r = longint'(bv[7:0]) * 256;
            K_MUL: begin
                r   = ua * ub;
                lat = 16;
            end
            default: r = 0;
        endcase
        if (!keep) m_result = r[15:0];
        exp_q.push_back({m_result, 3'b000, m_c, m_l, m_f, m_z, m_n});
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 after the op has been accepted.
    task automatic issue(input logic [3:0] op, input logic [3:0] ext,
                         input logic [15:0] av, input logic [15:0] bv);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        n_vec++;
        if (!in_ready) begin
            n_err++;
            $display("FAIL issue_wait: in_ready got %0b required 1 within 100 cycles", in_ready);
        end else begin
            opCode   = op;
            opExt    = ext;
            a        = av;
            b        = bv;
            in_valid = 1'b1;
            model_op(op, ext, av, bv, lat);
            exp_cyc_q.push_back(cyc + lat);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [15:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out_valid: got result %h PSR %h, required no output", result, PSR);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                check("result", 32'(result), 32'(mon_e[23:8]));
                check("psr", 32'(PSR), 32'(mon_e[7:0]));
                check("latency_cycle", mon_c, cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        opCode   = '0;
        opExt    = '0;
        a        = '0;
        b        = '0;
        model_reset();

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_psr", 32'(PSR), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk); #1;
        reset = 1'b1;
        idle(2);

        // directed arithmetic / compare / flag persistence
        issue(4'h0, 4'h5, 16'h8000, 16'h8000);  // ADD -> 0, PSR 0x14
        issue(4'h0, 4'hB, 16'h0003, 16'h0003);  // CMP -> PSR 0x16, result held
        issue(4'h0, 4'h9, 16'h0003, 16'h0004);  // SUB -> FFFF, C=1 F=0
        issue(4'h0, 4'hB, 16'h8000, 16'h0001);  // CMP register form
        issue(4'hB, 4'h0, 16'h8000, 16'h0001);  // CMPI -> L=0 Z=0 N=1
        issue(4'h5, 4'h0, 16'h8000, 16'h0080);  // ADDI -> 7F80, C=1 F=1
        issue(4'h1, 4'h0, 16'hFFFF, 16'h00F0);  // ANDI -> 00F0, PSR held
        issue(4'hD, 4'h0, 16'h1234, 16'hABCD);  // MOVI zero-extends
        issue(4'h9, 4'h0, 16'h0000, 16'h00FF);  // SUBI with -1
        // shifts and LUI
        issue(4'h8, 4'h4, 16'h0001, 16'h0003);  // LSH -> 8
        issue(4'h8, 4'h4, 16'h0002, 16'hFFFF);  // LSH -1 -> 1
        issue(4'h8, 4'h1, 16'h0001, 16'h001F);  // RSHI -1 -> 2
        issue(4'h8, 4'h0, 16'h0001, 16'h000F);  // LSHI 15 -> 8000
        issue(4'h8, 4'h0, 16'hFFFF, 16'h0010);  // LSHI -16 -> 0
        issue(4'h8, 4'h1, 16'hFFFF, 16'h0010);  // RSHI -16 -> 0
        issue(4'hF, 4'h0, 16'h0000, 16'h00FF);  // LUI -> FF00
        // memory address, unsupported encodings
        issue(4'h4, 4'h7, 16'h1000, 16'h0234);  // LOAD/STOR style -> a+b
        issue(4'h6, 4'h0, 16'h1234, 16'h5678);  // unsupported -> 0
        issue(4'h0, 4'h0, 16'h1234, 16'h5678);  // unsupported ext -> 0
        issue(4'h8, 4'h7, 16'h1234, 16'h0001);  // unsupported shift ext -> 0
        idle(2);

        // MUL: latency, in_ready low while busy, ignored ops, back-to-back ADD
        issue(4'h0, 4'hE, 16'd300, 16'd7);
        opCode   = 4'h0;
        opExt    = 4'h5;
        a        = 16'h1111;
        b        = 16'h2222;
        in_valid = 1'b1;
        for (int k = 1; k < W; k++) begin
            check("mul_in_ready_low", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("mul_in_ready_back", 32'(in_ready), 32'd1);
        issue(4'h0, 4'h5, 16'h0001, 16'h0002);
        issue(4'h0, 4'hE, 16'h0100, 16'h0100);  // -> 0
        issue(4'h0, 4'hE, 16'hFFFF, 16'hFFFF);  // -> 0001
        idle(3);

        // reset while MUL is in flight
        issue(4'h0, 4'h5, 16'h7FFF, 16'h0001);  // leave non-zero flags behind
        idle(3);
        issue(4'h0, 4'hE, 16'h1234, 16'h0042);
        idle(4);
        reset = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        model_reset();
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_psr", 32'(PSR), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("postrst_in_ready", 32'(in_ready), 32'd1);
        check("postrst_psr", 32'(PSR), 32'd0);
        check("postrst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk); #1;
        idle(20);

        // randomized ops
        for (int i = 0; i < 250; i++) begin
            int          pick;
            logic [7:0]  enc;
            logic [3:0]  op_r;
            logic [3:0]  ext_r;
            pick = $urandom_range(0, 20);
            if (pick == 20) begin
                enc = 8'($urandom);
            end else begin
                enc = ENC_TAB[pick];
            end
            op_r  = enc[7:4];
            ext_r = enc[3:0];
            if (pick != 20 && !(op_r inside {4'h0, 4'h8}))
                ext_r = 4'($urandom);
            issue(op_r, ext_r, pick_val(), pick_val());
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        // drain
        for (int k = 0; k < 100 && exp_q.size() > 0; k++) begin
            @(posedge clk); #1;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d outstanding results required 0", exp_q.size());
        end
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
